tdm_demultiplexer: RTL

//  Receive end of the time-multiplexed 4-bit datapath: takes words arriving one per beat
//  (ch0 marked by FrameStart), routes each to its channel slot, and presents a complete

---
 rtl/tdm_pkg.sv | 21 ++
 rtl/tdm_demultiplexer_channel_decoder.sv | 21 ++
 rtl/tdm_demultiplexer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdm_pkg;

    // Frame assembly state: HUNT waits for channel 0, COLLECT gathers the rest.
    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } tdm_state_e;

    // Default frame size and the matching channel index width.
    localparam int DEF_CHANNELS = 2;
    localparam int CH_IDX_W     = $clog2(DEF_CHANNELS);

    // Channel index width for an arbitrary frame size (CHANNELS >= 2).
    function automatic int ch_idx_w(input int channels);
        return $clog2(channels);
    endfunction

endpackage

// File: rtl/tdm_demultiplexer_channel_decoder.sv
// Turns a channel index plus write enable into one-hot capture-buffer strobes.
// Latency: combinational.
// Backpressure: none; the strobe is qualified entirely by the caller's write enable.
module channel_decoder #(
    parameter int SLOTS = 1,
    parameter int IDX_W = 1
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             we,
    output logic [SLOTS-1:0] strobe
);

    // One strobe per capture slot; at most one is high, and only when writing.
    always_comb begin
        strobe = '0;
        for (int i = 0; i < SLOTS; i++) begin
            strobe[i] = we && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/tdm_demultiplexer.sv
// Reassembles time-multiplexed channel words into a registered CHANNELS-word frame.
// Latency: frame valid 1 cycle after the last word of the frame is accepted.
// Backpressure: only the frame-completing word stalls, while an unconsumed frame is held.
module tdm_demultiplexer
    import tdm_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2
) (
    input  logic                      Clk,
    input  logic                      nReset,
    input  logic [WIDTH-1:0]          DataIn,
    input  logic                      DataValid,
    input  logic                      FrameStart,
    output logic                      DataReady,
    output logic [CHANNELS*WIDTH-1:0] DataOut,
    output logic                      FrameValid,
    input  logic                      FrameReady,
    output logic                      FrameError
);

    localparam int               IDX_W    = ch_idx_w(CHANNELS);
    localparam int               SLOTS    = CHANNELS - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    tdm_state_e                    state_q;
    tdm_state_e                    state_d;
    logic [IDX_W-1:0]              ch_idx_q;
    logic [IDX_W-1:0]              ch_idx_d;
    logic [SLOTS-1:0][WIDTH-1:0]   cap_buf_q;
    logic [SLOTS-1:0]              wr_stb;
    logic [IDX_W-1:0]              wr_idx;
    logic                          buf_we;
    logic                          accept;
    logic                          consume;
    logic                          complete;
    logic                          restart;

    // The completing word is the only one that needs the output register free.
    assign DataReady = nReset &&
                       !(state_q == COLLECT && ch_idx_q == LAST_IDX && FrameValid && !FrameReady);
    assign accept    = DataValid && DataReady;
    assign consume   = FrameValid && FrameReady;

    // Next-state and capture decisions for each accepted word.
    always_comb begin
        state_d  = state_q;
        ch_idx_d = ch_idx_q;
        buf_we   = 1'b0;
        wr_idx   = ch_idx_q;
        complete = 1'b0;
        restart  = 1'b0;
        if (accept) begin
            if (FrameStart) begin
                // Channel 0 always lands in slot 0, abandoning any partial frame.
                buf_we   = 1'b1;
                wr_idx   = '0;
                ch_idx_d = IDX_W'(1);
                state_d  = COLLECT;
                restart  = (state_q == COLLECT);
            end else if (state_q == COLLECT) begin
                if (ch_idx_q == LAST_IDX) begin
                    complete = 1'b1;
                    ch_idx_d = '0;
                    state_d  = HUNT;
                end else begin
                    buf_we   = 1'b1;
                    ch_idx_d = ch_idx_q + IDX_W'(1);
                end
            end
            // Accepted non-start words while hunting are dropped.
        end
    end

    channel_decoder #(
        .SLOTS (SLOTS),
        .IDX_W (IDX_W)
    ) u_channel_decoder (
        .idx    (wr_idx),
        .we     (buf_we),
        .strobe (wr_stb)
    );

    // FSM state and channel index registers.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= HUNT;
            ch_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_idx_q <= ch_idx_d;
        end
    end

    // Capture buffer holds channels 0..CHANNELS-2 of the frame in progress.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            cap_buf_q <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (wr_stb[i]) begin
                    cap_buf_q[i] <= DataIn;
                end
            end
        end
    end

    // Output frame register; a completion on the consume edge refills it with no bubble.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            DataOut    <= '0;
            FrameValid <= 1'b0;
            FrameError <= 1'b0;
        end else begin
            if (complete) begin
                DataOut    <= {DataIn, cap_buf_q};
                FrameValid <= 1'b1;
            end else if (consume) begin
                FrameValid <= 1'b0;
            end
            FrameError <= restart;
        end
    end

endmodule
